mips_cpu_mult_div: RTL and testbench
====================================

MIPS_CPU_MULT_DIV -- requirements
Module: mips_cpu_mult_div

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; ports are clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 start  input  1  request strobe, sampled on the rising clk edge.
REQ-005 op  input  3  operation: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-006 a  input  32  operand rs (register file read port 1 data).
REQ-007 b  input  32  operand rt (register file read port 2 data).
REQ-008 busy  output  1  high while an iterative operation is in progress.
REQ-009 done  output  1  one-cycle pulse when hi/lo have been updated by an iterative operation.
REQ-010 hi  output  32  HI register.
REQ-011 lo  output  32  LO register.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and FIN.
- IDLE: accept.
- RUN: 32 iterations.
- FIN: apply sign correction, write hi/lo, return to IDLE.
REQ-013 start SHALL be accepted only in IDLE; start in RUN or FIN SHALL be ignored, with no queuing.
REQ-014 On acceptance, the block SHALL latch a, b and op; later changes on a or b SHALL NOT affect the result.
REQ-015 MTHI/MTLO SHALL write a into hi or lo on the accepting edge; busy and done SHALL stay 0 and the other register SHALL be unchanged.
REQ-016 Reserved op values SHALL be accepted as no-ops: no state change, busy 0, done 0.
REQ-017 MULT/MULTU/DIV/DIVU accepted at edge N:
- busy=1 from after edge N until after edge N+33.
- hi/lo updated at edge N+33.
- done=1 for exactly the cycle between edges N+33 and N+34.
REQ-018 MULTU: {hi,lo} SHALL equal the unsigned 64-bit product, computed by 32-step shift-add.
REQ-019 MULT: {hi,lo} SHALL equal the signed 64-bit product, computed on magnitudes and negated in FIN when a[31]^b[31].
REQ-020 DIVU: lo = quotient, hi = remainder, computed by 32-step restoring division.
REQ-021 DIV: operate on magnitudes; quotient negative iff a[31]^b[31]; remainder takes the sign of a; truncation toward zero.
REQ-022 Divide by zero (b=0, DIV or DIVU): lo=32'hFFFFFFFF, hi=a; same latency and done pulse.
REQ-023 DIV with a=32'h80000000, b=32'hFFFFFFFF: lo=32'h80000000, hi=0.
REQ-024 start may be asserted in the done cycle; the block SHALL be back in IDLE then and accept it.
REQ-025 hi and lo SHALL hold their values between writes; intermediate iteration values SHALL NOT appear on hi/lo.

Reset
REQ-026 While reset=1, asynchronously: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0.
REQ-027 Reset asserted during RUN or FIN SHALL abort the operation; no later done pulse and no hi/lo write.
REQ-028 After reset deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-029 MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> after 33 cycles hi=32'hFFFFFFFE, lo=32'h00000001, done pulses once.
REQ-030 MULT a=-7 (32'hFFFFFFF9), b=3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB (-21).
REQ-031 DIV a=-7, b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); DIVU a=7, b=0 -> lo=32'hFFFFFFFF, hi=7.
REQ-032 MTHI a=32'h12345678 then MTLO a=32'h9ABCDEF0 on consecutive cycles -> hi/lo update on each accepting edge, busy stays 0.
REQ-033 Start MULTU; pulse start with MTLO mid-RUN; assert reset at iteration 10 -> MTLO ignored, busy=0 and hi=lo=0 immediately, no done.
REQ-034 Back-to-back: DIVU 100/7, with start held for MULTU 6*7 in the done cycle -> first result hi=2, lo=14; second accepted with no gap, hi=0, lo=42.

Source files
------------

// File: rtl/mips_cpu_mult_div.sv
// mips_cpu_mult_div: HI/LO multiply/divide unit for a MIPS-style core.
// Ports:
//   clk, reset     - rising-edge clock, asynchronous active-high reset
//   start, op      - request strobe and operation (000 MULTU, 001 MULT,
//                    010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op)
//   a, b           - rs / rt operands, latched when a request is accepted
//   busy           - iterative operation in progress (RUN or FIN)
//   done           - one-cycle pulse after hi/lo take an iterative result
//   hi, lo         - architectural HI / LO registers
module mips_cpu_mult_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic        is_div_q;   // 1: divide, 0: multiply
  logic        sign_q;     // negate product / quotient in FIN
  logic        rsign_q;    // negate remainder in FIN
  logic        dz_q;       // divide by zero
  logic [31:0] dvs_q;      // multiplicand (mult) or divisor (div) magnitude
  logic [31:0] acc_hi_q;   // product high half / partial remainder
  logic [31:0] acc_lo_q;   // multiplier bits / dividend bits -> quotient

  // op[0] selects the signed variants; op[2]==0 selects the iterative ops.
  logic        iter_req;
  logic [31:0] mag_a, mag_b;
  assign iter_req = start && !op[2];
  assign mag_a    = (op[0] && a[31]) ? (~a + 32'd1) : a;
  assign mag_b    = (op[0] && b[31]) ? (~b + 32'd1) : b;

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the 64-bit accumulator right by one.
  logic [32:0] msum;
  assign msum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, dvs_q} : 33'd0);

  // Restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor when it fits.
  logic [32:0] rsh;
  logic [33:0] diff;
  logic        ge;
  assign rsh  = {acc_hi_q, acc_lo_q[31]};
  assign diff = {1'b0, rsh} - {2'b00, dvs_q};
  assign ge   = ~diff[33];

  // Result formation in FIN.
  logic [63:0] prod, prod_fix;
  logic [31:0] quo_fix, rem_fix;
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = sign_q ? (~prod + 64'd1) : prod;
  assign quo_fix  = dz_q ? 32'hFFFF_FFFF : (sign_q ? (~acc_lo_q + 32'd1) : acc_lo_q);
  assign rem_fix  = rsign_q ? (~acc_hi_q + 32'd1) : acc_hi_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iter_req) state_d = RUN;
      RUN:     if (cnt_q == 5'd31) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      dz_q     <= 1'b0;
      dvs_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= (state_q == FIN);
      case (state_q)
        IDLE: if (start) begin
          if (!op[2]) begin
            cnt_q    <= '0;
            is_div_q <= op[1];
            sign_q   <= op[0] & (a[31] ^ b[31]);
            rsign_q  <= op[0] & a[31];
            dz_q     <= op[1] & (b == 32'd0);
            dvs_q    <= op[1] ? mag_b : mag_a;
            acc_hi_q <= '0;
            acc_lo_q <= op[1] ? mag_a : mag_b;
          end else if (op[1:0] == 2'b00) begin
            hi <= a;
          end else if (op[1:0] == 2'b01) begin
            lo <= a;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 5'd1;
          if (is_div_q) begin
            acc_hi_q <= ge ? diff[31:0] : rsh[31:0];
            acc_lo_q <= {acc_lo_q[30:0], ge};
          end else begin
            acc_hi_q <= msum[32:1];
            acc_lo_q <= {msum[0], acc_lo_q[31:1]};
          end
        end
        FIN: begin
          if (is_div_q) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_mult_div.sv
// Randomized scoreboard bench for mips_cpu_mult_div. Stimulus pushes the
// expected {hi,lo} and done cycle for each iterative op; a negedge monitor
// pops and compares whenever done is seen.
module tb_mips_cpu_mult_div;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  mips_cpu_mult_div dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] exp_q[$];
  int          cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic, returns {hi,lo}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, q, r, p;
    longint unsigned ux, uy;
    logic [63:0]     res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: res = ux * uy;
      3'd1: begin p = sx * sy; res = p; end
      3'd2: res = (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(ux % uy), 32'(ux / uy)};
      default: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", {32'd0, hi}, 64'hDEAD);
      end else begin
        logic [63:0] e;
        int          ec;
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        check("result_hilo", {hi, lo}, e);
        check("done_cycle", 64'(cyc), 64'(ec));
        check("busy_in_done", {63'd0, busy}, 64'd0);
        m_hi = e[63:32];
        m_lo = e[31:0];
      end
    end
  end

  // Wait for the next negedge at which the unit is idle.
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  // Drive a request now (caller sits just after a negedge, unit idle).
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int acc);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    acc = cyc;
    start = 1'b0;
    a = $urandom; b = $urandom;   // later operand changes must not matter
    if (!o[2]) begin
      exp_q.push_back(model(o, x, y));
      cyc_q.push_back(acc + 33);
      check("busy_after_accept", {63'd0, busy}, 64'd1);
      check("hilo_hold_accept", {hi, lo}, {m_hi, m_lo});
    end else begin
      if (o == 3'd4) m_hi = x;
      if (o == 3'd5) m_lo = x;
      check("mt_or_noop_hilo", {hi, lo}, {m_hi, m_lo});
      check("mt_or_noop_busy", {62'd0, busy, done}, 64'd0);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int acc, acc1, acc2;
    #12;
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_flags", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases from the required scenarios.
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc); wait_idle();
    run_op(3'd1, 32'hFFFF_FFF9, 32'd3, acc);         wait_idle();
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, acc);         wait_idle();
    run_op(3'd2, 32'd7, 32'd0, acc);                 wait_idle();
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, acc); wait_idle();
    run_op(3'd3, 32'hFFFF_FFF0, 32'd0, acc);         wait_idle();
    run_op(3'd4, 32'h1234_5678, 32'd0, acc);         wait_idle();
    run_op(3'd5, 32'h9ABC_DEF0, 32'd0, acc);         wait_idle();
    run_op(3'd6, 32'hAAAA_AAAA, 32'd1, acc);         wait_idle();
    run_op(3'd7, 32'h5555_5555, 32'd1, acc);         wait_idle();

    // Back-to-back: second start issued in the done cycle.
    run_op(3'd2, 32'd100, 32'd7, acc1); wait_idle();
    run_op(3'd0, 32'd6, 32'd7, acc2);
    check("b2b_no_gap", 64'(acc2), 64'(acc1 + 34));
    wait_idle();

    // Randomized mix.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      run_op(o, pick(), pick(), acc);
      wait_idle();
    end

    // Ignored start mid-RUN, then abort by reset at iteration 10.
    run_op(3'd0, 32'h0001_0003, 32'h0000_0777, acc);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'hCAFE_F00D;
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo_ignored_in_run", {32'd0, lo}, {32'd0, m_lo});
    check("busy_in_run", {63'd0, busy}, 64'd1);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_flags", {62'd0, busy, done}, 64'd0);
    exp_q.delete();
    cyc_q.delete();
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);   // any done here is flagged by the monitor
    check("after_abort_hilo", {hi, lo}, 64'd0);

    // First start after reset is accepted.
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, acc); wait_idle();

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin
        @(negedge clk);
        n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
